// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the cache PC, queues returned instructions in order, and hands them to decode.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          Q_DEPTH  = 4,
  parameter int          Q_AW     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [31:0]     instr_in,
  output logic [31:0]     pc,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [31:0]     dec_pc,
  output logic [Q_AW:0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MISS, S_FULL} state_t;

  localparam logic [Q_AW:0] DEPTH_C = (Q_AW + 1)'(Q_DEPTH);

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [Q_AW-1:0] head_q, head_d;
  logic [Q_AW-1:0] tail_q, tail_d;
  logic [Q_AW:0]   count_q, count_d;
  logic [31:0]     mem_pc_q    [Q_DEPTH];
  logic [31:0]     mem_instr_q [Q_DEPTH];

  logic push;
  logic pop;
  logic can_push;
  logic unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign can_push  = (count_q < DEPTH_C) || pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH, S_MISS: begin
          if (stall) begin
            state_d = S_MISS;
          end else if (can_push) begin
            push    = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end else begin
            state_d = S_FULL;
          end
        end
        S_FULL: if (pop) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end

    // Redirect empties the queue; the same-cycle pop is simply absorbed.
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + Q_AW'(1);
      if (pop)  head_d = head_q + Q_AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (Q_AW + 1)'(1);
        2'b01:   count_d = count_q - (Q_AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[tail_q]    <= pc_q;
      mem_instr_q[tail_q] <= instr_in;
    end
  end

  assign pc        = pc_q;
  assign q_count   = count_q;
  assign dec_pc    = dec_valid ? mem_pc_q[head_q]    : 32'h0;
  assign dec_instr = dec_valid ? mem_instr_q[head_q] : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall && (state_q != S_IDLE) && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid, dec_ready;
  logic [31:0] instr_in, redirect_pc;

  logic [31:0] pc_a, dec_instr_a, dec_pc_a;
  logic        dec_valid_a;
  logic [2:0]  q_count_a;
  logic [31:0] pc_b, dec_instr_b, dec_pc_b;
  logic        dec_valid_b;
  logic [2:0]  q_count_b;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .Q_DEPTH(4), .Q_AW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_in(instr_in), .pc(pc_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid_a), .dec_ready(dec_ready), .dec_instr(dec_instr_a),
    .dec_pc(dec_pc_a), .q_count(q_count_a)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_a), .perf_stall_cycles(ps_a)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .Q_DEPTH(4), .Q_AW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_in(instr_in), .pc(pc_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid_b), .dec_ready(dec_ready), .dec_instr(dec_instr_b),
    .dec_pc(dec_pc_b), .q_count(q_count_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_b), .perf_stall_cycles(ps_b)
`endif
  );

  int n_checks;
  int n_fail;

  // Reference model: an in-order list of (pc, instr) pairs plus a few flags.
  bit          sel_b;
  logic [31:0] m_reset_pc, m_pc, m_fetched, m_stalls;
  bit          m_warm, m_blocked;
  logic [63:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit pop;
    if (!rst_n) begin
      m_pc = m_reset_pc; m_q.delete(); m_warm = 1; m_blocked = 0;
      m_fetched = 0; m_stalls = 0;
      return;
    end
    pop = (m_q.size() != 0) && dec_ready;
    if (stall && !m_warm && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (pop) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      m_warm = 0; m_blocked = 0;
    end else if (m_warm) begin
      m_warm = 0;
    end else if (m_blocked) begin
      if (pop) m_blocked = 0;
    end else if (!stall) begin
      if (m_q.size() < 4) begin
        m_q.push_back({m_pc, instr_in});
        m_pc += 32'd4;
        if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
      end else begin
        m_blocked = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] g_pc, g_dpc, g_dins;
    logic        g_v;
    logic [2:0]  g_cnt;
    g_pc  = sel_b ? pc_b        : pc_a;
    g_dpc = sel_b ? dec_pc_b    : dec_pc_a;
    g_dins= sel_b ? dec_instr_b : dec_instr_a;
    g_v   = sel_b ? dec_valid_b : dec_valid_a;
    g_cnt = sel_b ? q_count_b   : q_count_a;
    check_eq("model.pc", g_pc, m_pc);
    check_eq("model.q_count", 32'(g_cnt), 32'(m_q.size()));
    check_eq("model.dec_valid", 32'(g_v), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("model.dec_pc", g_dpc, m_q[0][63:32]);
      check_eq("model.dec_instr", g_dins, m_q[0][31:0]);
    end
`ifdef FETCH_PERF_EN
    check_eq("model.perf_fetched", sel_b ? pf_b : pf_a, m_fetched);
    check_eq("model.perf_stall", sel_b ? ps_b : ps_a, m_stalls);
`endif
  endtask

  // One clock: drive at negedge, let the edge happen, then model and compare.
  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                       input logic dr, input bit pat, input logic [31:0] ins);
    @(negedge clk);
    rst_n = r; stall = s; redirect_valid = rv; redirect_pc = rp; dec_ready = dr;
    instr_in = pat ? (m_pc ^ 32'hA5A5_A5A5) : ins;
    #1;
    if (sel_b ? (dec_valid_b && dec_ready && rst_n) : (dec_valid_a && dec_ready && rst_n))
      $display("deq pc=%h instr=%h", sel_b ? dec_pc_b : dec_pc_a, sel_b ? dec_instr_b : dec_instr_a);
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; sel_b = 0;
    m_reset_pc = 32'h0; m_pc = 0; m_fetched = 0; m_stalls = 0; m_warm = 1; m_blocked = 0;
    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; dec_ready = 0; instr_in = 0;

    // Reset then streaming with the pc^A5A5A5A5 pattern.
    repeat (2) cycle(0, 0, 0, 0, 1, 1, 0);
    check_eq("rst.pc", pc_a, 32'h0);
    check_eq("rst.q_count", 32'(q_count_a), 32'd0);
    check_eq("rst.dec_valid", 32'(dec_valid_a), 32'd0);
    check_eq("rst.dec_pc", dec_pc_a, 32'h0);
    check_eq("rst.dec_instr", dec_instr_a, 32'h0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("idle.pc", pc_a, 32'h0);
    check_eq("idle.dec_valid", 32'(dec_valid_a), 32'd0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("seq.pc4", pc_a, 32'h4);
    check_eq("seq.dec_pc0", dec_pc_a, 32'h0);
    check_eq("seq.dec_instr0", dec_instr_a, 32'hA5A5_A5A5);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("seq.pc8", pc_a, 32'h8);
    check_eq("seq.dec_pc4", dec_pc_a, 32'h4);
    check_eq("seq.dec_instr4", dec_instr_a, 32'hA5A5_A5A1);

    // Five miss cycles at pc=8.
    repeat (5) begin
      cycle(1, 1, 0, 0, 1, 1, 0);
      check_eq("miss.pc_hold", pc_a, 32'h8);
    end
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("miss.pc_next", pc_a, 32'hC);
    check_eq("miss.dec_pc", dec_pc_a, 32'h8);
    check_eq("miss.dec_instr", dec_instr_a, 32'hA5A5_A5AD);

    // Fill with decode blocked, then drain.
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
    repeat (5) cycle(1, 0, 0, 0, 0, 1, 0);
    check_eq("full.q_count", 32'(q_count_a), 32'd4);
    check_eq("full.pc", pc_a, 32'h10);
    repeat (3) begin
      cycle(1, 0, 0, 0, 0, 1, 0);
      check_eq("full.pc_hold", pc_a, 32'h10);
    end
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("drain.head4", dec_pc_a, 32'h4);
    check_eq("drain.pc_hold", pc_a, 32'h10);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("drain.head8", dec_pc_a, 32'h8);
    check_eq("drain.pc_resume", pc_a, 32'h14);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("drain.headC", dec_pc_a, 32'hC);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("drain.head10", dec_pc_a, 32'h10);

    // Simultaneous push and pop at full.
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
    repeat (5) cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("pushpop.q_count", 32'(q_count_a), 32'd4);
    check_eq("pushpop.head", dec_pc_a, 32'h4);
    check_eq("pushpop.pc", pc_a, 32'h14);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_eq("pushpop.q_count2", 32'(q_count_a), 32'd4);
    check_eq("pushpop.head2", dec_pc_a, 32'h8);

    // Redirect during a miss with three entries queued.
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
    repeat (4) cycle(1, 0, 0, 0, 0, 1, 0);
    check_eq("redir.pre_count", 32'(q_count_a), 32'd3);
    cycle(1, 1, 0, 0, 0, 1, 0);
    cycle(1, 1, 1, 32'h0000_1003, 0, 1, 0);
    check_eq("redir.pc", pc_a, 32'h1000);
    check_eq("redir.q_count", 32'(q_count_a), 32'd0);
    check_eq("redir.dec_valid", 32'(dec_valid_a), 32'd0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    check_eq("redir.first_pc", dec_pc_a, 32'h1000);
    check_eq("redir.first_valid", 32'(dec_valid_a), 32'd1);

    // Randomized traffic.
    repeat (2) cycle(0, 0, 0, 0, 0, 0, $urandom);
    repeat (1500)
      cycle($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
            $urandom, $urandom_range(0, 99) < 60, 0, $urandom);

    // Wrap-around instance.
    sel_b = 1; m_reset_pc = 32'hFFFF_FFF8;
    repeat (2) cycle(0, 0, 0, 0, 1, 0, $urandom);
    check_eq("wrap.rst_pc", pc_b, 32'hFFFF_FFF8);
    cycle(1, 0, 0, 0, 1, 0, $urandom);
    cycle(1, 0, 0, 0, 1, 0, $urandom);
    check_eq("wrap.pcFFFC", pc_b, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 1, 0, $urandom);
    check_eq("wrap.pc0", pc_b, 32'h0000_0000);
    repeat (3) cycle(1, 1, 0, 0, 0, 0, $urandom);
    cycle(0, 1, 0, 0, 0, 0, $urandom);
    check_eq("wrap.rst_miss_pc", pc_b, 32'hFFFF_FFF8);
    check_eq("wrap.rst_miss_count", 32'(q_count_b), 32'd0);
    check_eq("wrap.rst_miss_valid", 32'(dec_valid_b), 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("wrap.perf_fetched0", pf_b, 32'd0);
    check_eq("wrap.perf_stall0", ps_b, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction cache top module.
- Generates the sequential `pc` the cache consumes and honours the cache's `stall`.
- Captures the returned `instr` into a small in-order fetch queue and hands (pc, instr) pairs to decode over a valid/ready handshake.
- Supports branch redirect with queue flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- Q_DEPTH, 4, fetch-queue entries (power of 2, 2..16).
- Q_AW, 2, queue pointer width, log2(Q_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- stall  in  1  from cache; 1 = miss in progress, `instr_in` not valid for current `pc`.
- instr_in  in  32  from cache; instruction for current `pc`, valid when stall=0.
- pc  out  32  to cache; current fetch address, word aligned.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0).
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode accepts head this cycle.
- dec_instr  out  32  queue-head instruction.
- dec_pc  out  32  queue-head address.
- q_count  out  Q_AW+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at posedge):
  - `pc`=RESET_PC, queue empty, `q_count`=0, `dec_valid`=0.
  - `dec_instr`/`dec_pc`=0; FSM=S_IDLE.
  - Reset mid-miss or mid-redirect discards everything.
- FSM:
  - S_IDLE: one cycle after reset release, no capture; go to S_FETCH.
  - S_FETCH:
    - If stall=0 and enqueue allowed: push {pc, instr_in}, `pc`<=pc+4.
    - If stall=1: go to S_MISS, `pc` held.
    - If enqueue is not allowed: go to S_FULL, `pc` held.
  - S_MISS: `pc` held while stall=1; on the first stall=0 cycle, capture as in S_FETCH and return to S_FETCH (or S_FULL if blocked).
  - S_FULL: `pc` held, no capture; when a dequeue occurs, return to S_FETCH next cycle.
- Enqueue allowed: count<Q_DEPTH, or a dequeue happens the same cycle (simultaneous push/pop at full is legal, count unchanged).
- Dequeue: `dec_valid`&`dec_ready`; head advances; `dec_*` are registered head outputs, valid the cycle after the push (1-cycle cache-to-decode latency).
- Redirect (highest priority, any state except reset):
  - Queue flushed and the same-cycle cache response discarded.
  - `pc`<={redirect_pc[31:2],2'b00}, FSM=S_FETCH.
  - A dequeue in the same cycle is still honoured (head consumed before flush); `dec_valid`=0 next cycle.
- Redirect during stall: `pc` changes immediately. The cache must accept an address change mid-miss; the stale line fill is not forwarded.
- PC arithmetic: 32-bit wrap, 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag.
- `pc`[1:0] always 0.
- Queue pointers wrap modulo Q_DEPTH; `q_count` never exceeds Q_DEPTH.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall_cycles (32).
  - perf_fetched counts enqueues.
  - perf_stall_cycles counts cycles with stall=1 outside S_IDLE.
  - Both saturate at 32'hFFFF_FFFF and clear on reset only.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, stall=0, instr_in=pc^32'hA5A5_A5A5, dec_ready=1:
  - pc sequences 0,4,8,C.
  - dec_pc/dec_instr pairs match (0,A5A5A5A5),(4,A5A5A5A1).
  - No gaps after the first beat.
- stall=1 for 5 cycles while pc=8: pc holds 8, no enqueue; on stall=0, pc→C and pair (8,instr) appears one cycle later.
- dec_ready=0, stall=0:
  - After 4 pushes q_count=4, FSM holds pc=0x10.
  - Raise dec_ready: drain in order 0,4,8,C, then fetch resumes at 0x10.
- Full queue, dec_ready=1 and stall=0 in the same cycle: push and pop together, q_count stays 4, no entry lost or duplicated.
- redirect_valid with redirect_pc=32'h0000_1003 while stall=1 and q_count=3:
  - Next cycle pc=0x1000, q_count=0, dec_valid=0.
  - The next captured pair has pc 0x1000.
- RESET_PC=32'hFFFF_FFF8:
  - pc wraps FFF8→FFFC→0000_0000.
  - rst_n=0 asserted mid-miss returns pc to FFF8 with empty queue.
  - With FETCH_PERF_EN, both counters read 0.
